// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display constants and scan-state encoding for the seven-segment scan path.
package seg_scan_ctrl_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] AN_OFF     = 8'hFF;
    localparam int         NUM_DIGITS = 8;
    localparam int         IDX_W      = $clog2(NUM_DIGITS);

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [7:0] an_onehot(input logic [IDX_W-1:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_clk_prescaler.sv
// Free-running counter with synchronous clear, count enable, terminal-count pulse and MSB tap.
// Latency: tc is combinational from the count register; msb is a register bit.
// Backpressure: none; cnt_en simply stalls the count.
module seg_scan_ctrl_clk_prescaler #(
    parameter int WIDTH = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic tc,
    output logic msb
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt_en) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign tc  = cnt_en && (&cnt);
    assign msb = cnt[WIDTH-1];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with flash generator; DISP_BLANK_EN adds inter-digit dead time.
// Latency: one cycle from scan_idx or seg_txt change to an/segment.
// Backpressure: none; en=0 blanks the display and parks the scan at digit 0.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 17,
    parameter int FLASH_DIV = 25,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] seg_txt,
    input  logic        en,
    output logic        flash,
    output logic [7:0]  an,
    output logic [7:0]  segment,
    output logic [2:0]  scan_idx,
    output logic        frame_done
);

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             scan_run;
    logic             scan_tc;
    logic             scan_msb_unused;
    logic             flash_wrap_unused;
    logic [7:0]       an_d, seg_d;
    logic             fd_d;

    assign scan_run = en && (state_q == SHOW);

    seg_scan_ctrl_clk_prescaler #(.WIDTH(SCAN_DIV)) u_scan_presc (
        .clk    (clk),
        .rst    (rst),
        .clr    (~en),
        .cnt_en (scan_run),
        .tc     (scan_tc),
        .msb    (scan_msb_unused)
    );

    seg_scan_ctrl_clk_prescaler #(.WIDTH(FLASH_DIV)) u_flash_presc (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .cnt_en (1'b1),
        .tc     (flash_wrap_unused),
        .msb    (flash)
    );

`ifdef DISP_BLANK_EN
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    logic [BW-1:0] blank_cnt;
    logic          blank_done;

    // Dead-time counter only runs while parked in BLANK.
    always_ff @(posedge clk) begin
        if (rst || !en || (state_q != BLANK)) begin
            blank_cnt <= '0;
        end else begin
            blank_cnt <= blank_cnt + BW'(1);
        end
    end

    assign blank_done = (blank_cnt == BW'(BLANK_CYC - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SHOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef DISP_BLANK_EN
        if (!en) begin
            state_d = SHOW;
        end else begin
            case (state_q)
                SHOW:    if (scan_tc)    state_d = BLANK;
                BLANK:   if (blank_done) state_d = SHOW;
                default: state_d = SHOW;
            endcase
        end
`else
        state_d = SHOW;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            idx_q <= '0;
        end else if (scan_tc) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // In BLANK the segment bus already carries the next digit so it settles before the anode turns on.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        fd_d  = 1'b0;
        if (en) begin
            seg_d = seg_txt[{idx_q, 3'b000} +: 8];
            an_d  = (state_q == SHOW) ? an_onehot(idx_q) : AN_OFF;
            fd_d  = scan_tc && (idx_q == IDX_W'(NUM_DIGITS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= AN_OFF;
            segment    <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            segment    <= seg_d;
            frame_done <= fd_d;
        end
    end

    assign scan_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised scoreboard bench for seg_scan_ctrl; honours DISP_BLANK_EN for the dead-time variant.
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 2;
    localparam int FLASH_DIV = 4;
    localparam int BLANK_CYC = 2;
    localparam int S         = 1 << SCAN_DIV;
    localparam int FMOD      = 1 << FLASH_DIV;
`ifdef DISP_BLANK_EN
    localparam int P = S + BLANK_CYC;
`else
    localparam int P = S;
`endif

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic [2:0] idx;
        logic       fd;
        logic       fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [63:0] seg_txt = '0;
    logic        flash;
    logic [7:0]  an;
    logic [7:0]  segment;
    logic [2:0]  scan_idx;
    logic        frame_done;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   t_en     = 0;
    int   fcnt     = 0;

    seg_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .FLASH_DIV (FLASH_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_txt    (seg_txt),
        .en         (en),
        .flash      (flash),
        .an         (an),
        .segment    (segment),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Reference: position in the scan follows from edges elapsed since enable, digit period P.
    function automatic exp_t model(input logic r, input logic e, input logic [63:0] s);
        exp_t       x;
        logic [7:0] one;
        int         k, ph, d;
        one = 8'h01;
        x   = '{an: 8'hFF, seg: 8'hFF, idx: 3'd0, fd: 1'b0, fl: 1'b0};
        if (r) begin
            fcnt = 0;
            t_en = 0;
        end else begin
            fcnt = (fcnt + 1) % FMOD;
            x.fl = (fcnt >= FMOD / 2);
            if (!e) begin
                t_en = 0;
            end else begin
                k  = t_en / P;
                ph = t_en % P;
                if (ph < S) begin
                    d    = k % 8;
                    x.an = ~(one << d);
                end else begin
                    d    = (k + 1) % 8;
                end
                x.seg = s[8*d +: 8];
                x.idx = 3'(((t_en + P - S + 1) / P) % 8);
                x.fd  = (ph == S - 1) && (k % 8 == 7);
                t_en++;
            end
        end
        return x;
    endfunction

    task automatic step(input logic r, input logic e, input logic [63:0] s);
        @(negedge clk);
        rst     = r;
        en      = e;
        seg_txt = s;
        exp_q.push_back(model(r, e, s));
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("an",         an,                 x.an);
                check("segment",    segment,            x.seg);
                check("scan_idx",   {5'b0, scan_idx},   {5'b0, x.idx});
                check("frame_done", {7'b0, frame_done}, {7'b0, x.fd});
                check("flash",      {7'b0, flash},      {7'b0, x.fl});
            end
        end
    end

    initial begin : driver
        logic [63:0] img;
        logic        e;
        logic        r;
        img = 64'h8899AABBCCDDEEFF;
        step(1'b1, 1'b0, img);
        step(1'b1, 1'b0, img);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, img);
        for (int i = 0; i < 8 * P * 2 + 5; i++) step(1'b0, 1'b1, img);
        // Random phase: live image edits, enable drops and mid-scan resets.
        e = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3, 0) == 0) img[8*$urandom_range(7, 0) +: 8] = 8'($urandom);
            if (e) e = ($urandom_range(59, 0) != 0);
            else   e = ($urandom_range(3, 0) == 0);
            r = ($urandom_range(199, 0) == 0);
            step(r, e, img);
        end
        step(1'b0, 1'b0, img);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display.
- Consumes the 64-bit segment image produced by the hex-to-segment decoder: 8 bytes, digit k = seg_txt[8k+7:8k].
- Drives one digit at a time through active-low anodes and a shared 8-bit segment bus.
- Generates the flash waveform that the decoder ANDs with its per-digit blink enables.

Parameters:
SCAN_DIV, 17, log2 of clk cycles each digit is shown; the prescaler is SCAN_DIV bits wide.
FLASH_DIV, 25, flash output = bit FLASH_DIV-1 of a free-running FLASH_DIV-bit counter.
BLANK_CYC, 16, dead-time cycles between digits; used only with DISP_BLANK_EN; must be ≥1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
seg_txt  input  64  segment image; byte k belongs to digit k
en  input  1  display enable
flash  output  1  blink waveform to the decoder (1 = blink-enabled digits blanked)
an  output  8  digit anodes, active-low, one-hot-low while showing
segment  output  8  segment byte for the active digit
scan_idx  output  3  index of the digit currently selected
frame_done  output  1  one-cycle pulse when scan_idx wraps from 7 to 0

Behaviour:
Clocking and reset
- Single clock domain. All outputs are registered.
- Reset is synchronous, active-high and has priority over everything, including mid-scan.
- Reset values: an=8'hFF, segment=8'hFF, scan_idx=0, frame_done=0, flash=0; prescaler, flash counter and FSM state (SHOW) all cleared.

Flash
- FLASH_DIV-bit counter increments every cycle and ignores en.
- flash = counter[FLASH_DIV-1], giving a square wave with period 2^FLASH_DIV cycles.

Scan
- While en=0: prescaler and scan_idx held at 0, an=8'hFF, segment=8'hFF, frame_done=0.
- While en=1, state SHOW: prescaler counts 0..2^SCAN_DIV-1, then wraps.
- At the terminal count without DISP_BLANK_EN: scan_idx increments modulo 8 (7 wraps to 0).
- an = ~(8'b1 << scan_idx) and segment = seg_txt[8*scan_idx +: 8], both registered from current state.
- Latency is 1 cycle from a change in scan_idx or seg_txt to the outputs. seg_txt is sampled live, not latched per frame.
- After en rises, digit 0 appears on the following cycle.
- frame_done is high for exactly the cycle in which scan_idx changes 7→0.
- en falling mid-digit: outputs blank next cycle; scan_idx and prescaler are cleared.

Optional Feature:
Macro: DISP_BLANK_EN. Enables anti-ghosting dead time between digits.
- Defined: the FSM has two states, SHOW and BLANK.
  - At SHOW terminal count: scan_idx advances (frame_done as above), prescaler clears, FSM enters BLANK.
  - In BLANK: an=8'hFF and segment shows the new digit's byte (pre-settle).
  - After BLANK_CYC cycles the FSM returns to SHOW, prescaler cleared.
  - en=0 forces SHOW with cleared counters.
  - Each digit period is 2^SCAN_DIV + BLANK_CYC cycles.
- Undefined: SHOW only; each digit period is 2^SCAN_DIV cycles; BLANK_CYC is ignored.

Decomposition:
- Shared display package holds:
  - SEG_BLANK = 8'hFF
  - AN_OFF = 8'hFF
  - NUM_DIGITS = 8
  - Scan state enum {SHOW, BLANK}
- Natural sub-module: clk_prescaler. Parameterised free-running counter with a terminal-count pulse and an MSB output. It is instantiated once for the scan tick and once for flash.

Test Plan:
Benches run with SCAN_DIV=2, FLASH_DIV=4, BLANK_CYC=2.
1. Reset, then en=0 for 10 cycles → an=FF, segment=FF, scan_idx=0, frame_done=0; flash toggles every 8 cycles.
2. seg_txt=64'h8899AABBCCDDEEFF, en=1 → each digit held 4 cycles; an sequence FE,FD,FB,…,7F; segment sequence FF,EE,DD,…,88; frame_done pulses once every 32 cycles, on the 7→0 step.
3. Change seg_txt byte 3 while digit 3 is active → segment updates exactly 1 cycle later; an is unchanged.
4. Drop en mid-digit 5 → next cycle an=FF and segment=FF. Re-raise en → digit 0 (byte 0) appears on the next cycle.
5. Assert rst for 1 cycle at scan_idx=6 → all outputs take their reset values on the next edge. After release, the scan restarts at digit 0.
6. With DISP_BLANK_EN defined → each digit shows 4 cycles, then 2 cycles with an=FF and segment equal to the next byte; frame period is 48 cycles.
